// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light phase controller.
package tl_pkg;

  localparam int unsigned TL_TIMER_W = 8;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRed1    = 3'd2,
    StPedWalk    = 3'd3,
    StSideGreen  = 3'd4,
    StSideYellow = 3'd5,
    StAllRed2    = 3'd6
  } tl_state_t;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase down-counter: loads a duration on phase entry, counts 1 Hz ticks down to 0 and saturates.
module tl_phase_timer
  import tl_pkg::*;
#(
  parameter logic [TL_TIMER_W-1:0] RESET_VAL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [TL_TIMER_W-1:0] load_val,
  input  logic                  tick,
  output logic [TL_TIMER_W-1:0] count,
  output logic                  expiring
);

  logic [TL_TIMER_W-1:0] count_q;

  // Load has priority over the tick decrement so a new phase starts at its full duration.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count    = count_q;
  assign expiring = tick && (count_q == TL_TIMER_W'(1));

endmodule

// File: rtl/tl_phase_controller.sv
// Two-road traffic-light phase controller with optional pedestrian crossing.
// Build option: define TL_PED_CROSSING_EN to include the pedestrian walk phase.
module tl_phase_controller
  import tl_pkg::*;
#(
  parameter int unsigned MAIN_GREEN_MIN = 10,
  parameter int unsigned SIDE_GREEN     = 6,
  parameter int unsigned YELLOW         = 3,
  parameter int unsigned ALL_RED        = 1,
  parameter int unsigned PED_WALK       = 5
) (
  input  logic                  clk,
  input  logic                  Reset_Sync,
  input  logic                  tick,
  input  logic                  side_sensor,
  input  logic                  ped_req,
  output logic [2:0]            main_light,
  output logic [2:0]            side_light,
  output logic                  walk,
  output logic [TL_TIMER_W-1:0] phase_remaining
);

  // Durations outside 1..255 cannot be represented by the phase timer.
  if (MAIN_GREEN_MIN < 1 || MAIN_GREEN_MIN > 255 || SIDE_GREEN < 1 || SIDE_GREEN > 255 ||
      YELLOW < 1 || YELLOW > 255 || ALL_RED < 1 || ALL_RED > 255 ||
      PED_WALK < 1 || PED_WALK > 255) begin : g_bad_duration
    $fatal(1, "tl_phase_controller: every phase duration must be in 1..255");
  end

  tl_state_t             state_q, state_d;
  logic                  advance;
  logic                  ped_pending;
  logic                  expiring;
  logic [TL_TIMER_W-1:0] count;
  logic [TL_TIMER_W-1:0] load_val;

  function automatic logic [TL_TIMER_W-1:0] dur_of(input tl_state_t st);
    case (st)
      StMainGreen:                dur_of = TL_TIMER_W'(MAIN_GREEN_MIN);
      StMainYellow, StSideYellow: dur_of = TL_TIMER_W'(YELLOW);
      StPedWalk:                  dur_of = TL_TIMER_W'(PED_WALK);
      StSideGreen:                dur_of = TL_TIMER_W'(SIDE_GREEN);
      default:                    dur_of = TL_TIMER_W'(ALL_RED);
    endcase
  endfunction

  // Next-state: timed phases leave on the expiring tick; main green also needs demand.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StMainGreen: begin
        if (tick && (count <= TL_TIMER_W'(1)) && (side_sensor || ped_pending)) begin
          state_d = StMainYellow;
        end
      end
      StMainYellow: if (expiring) state_d = StAllRed1;
      StAllRed1:    if (expiring) state_d = ped_pending ? StPedWalk : StSideGreen;
      StPedWalk:    if (expiring) state_d = side_sensor ? StSideGreen : StAllRed2;
      StSideGreen:  if (expiring) state_d = StSideYellow;
      StSideYellow: if (expiring) state_d = StAllRed2;
      StAllRed2:    if (expiring) state_d = StMainGreen;
      default:      state_d = StAllRed2;
    endcase
  end

  assign advance  = (state_d != state_q);
  assign load_val = dur_of(state_d);

  // State register; reset lands in the clearance phase so both roads start red.
  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      state_q <= StAllRed2;
    end else begin
      state_q <= state_d;
    end
  end

  tl_phase_timer #(
    .RESET_VAL (TL_TIMER_W'(ALL_RED))
  ) u_timer (
    .clk      (clk),
    .rst      (Reset_Sync),
    .load     (advance),
    .load_val (load_val),
    .tick     (tick),
    .count    (count),
    .expiring (expiring)
  );

`ifdef TL_PED_CROSSING_EN
  logic ped_pending_q;

  // Pedestrian latch; clearing on walk entry wins over a same-cycle request.
  always_ff @(posedge clk) begin
    if (Reset_Sync) begin
      ped_pending_q <= 1'b0;
    end else if (advance && (state_d == StPedWalk)) begin
      ped_pending_q <= 1'b0;
    end else if (ped_req) begin
      ped_pending_q <= 1'b1;
    end
  end

  assign ped_pending = ped_pending_q;
  assign walk        = (state_q == StPedWalk);
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pending    = 1'b0;
  assign walk           = 1'b0;
`endif

  // Moore lamp decode from the state register only.
  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    case (state_q)
      StMainGreen:  main_light = LIGHT_GREEN;
      StMainYellow: main_light = LIGHT_YELLOW;
      StSideGreen:  side_light = LIGHT_GREEN;
      StSideYellow: side_light = LIGHT_YELLOW;
      default: ;
    endcase
  end

  assign phase_remaining = count;

endmodule

// File: tb/tb_tl_phase_controller.sv
// Scoreboard bench for tl_phase_controller: stimulus queues expected lamp/timer snapshots
// tagged with a cycle number, a monitor pops and compares them on the falling edge.
module tb_tl_phase_controller;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       Reset_Sync = 1'b1;
  logic       tick = 1'b0;
  logic       side_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [7:0] phase_remaining;

  tl_phase_controller dut (
    .clk             (clk),
    .Reset_Sync      (Reset_Sync),
    .tick            (tick),
    .side_sensor     (side_sensor),
    .ped_req         (ped_req),
    .main_light      (main_light),
    .side_light      (side_light),
    .walk            (walk),
    .phase_remaining (phase_remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic [2:0] m;
    logic [2:0] s;
    logic       w;
    logic [7:0] rem;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: lamp exclusivity every cycle, plus any expectations due this cycle.
  always @(negedge clk) begin
    n_tests++;
    if (main_light != R && side_light != R) begin
      n_fail++;
      $display("FAIL exclusive cyc %0d: main=%b side=%b, one must be 100", cyc, main_light,
               side_light);
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (e.cyc != cyc || main_light !== e.m || side_light !== e.s || walk !== e.w ||
          phase_remaining !== e.rem) begin
        n_fail++;
        $display("FAIL %s cyc %0d (due %0d): got main=%b side=%b walk=%b rem=%0d, expected main=%b side=%b walk=%b rem=%0d",
                 e.nm, cyc, e.cyc, main_light, side_light, walk, phase_remaining, e.m, e.s,
                 e.w, e.rem);
      end
    end
  end

  // One clock: drive inputs, queue the state expected after the next rising edge.
  task automatic step(input logic t, input logic s, input logic p, input logic r,
                      input logic [2:0] em, input logic [2:0] es, input logic ew,
                      input int erem, input string nm);
    exp_t e;
    tick = t; side_sensor = s; ped_req = p; Reset_Sync = r;
    e.cyc = cyc + 1; e.nm = nm; e.m = em; e.s = es; e.w = ew; e.rem = 8'(erem);
    q.push_back(e);
    @(negedge clk);
  endtask

  // A tick cycle followed by an idle cycle; nothing may change on the idle one.
  task automatic tick_expect(input logic s, input logic p, input logic [2:0] em,
                             input logic [2:0] es, input logic ew, input int erem,
                             input string nm);
    step(1'b1, s, p, 1'b0, em, es, ew, erem, nm);
    step(1'b0, s, 1'b0, 1'b0, em, es, ew, erem, {nm, "_idle"});
  endtask

  // Run a timed phase of dur ticks; the last tick must move to the next phase.
  task automatic run_phase(input string nm, input logic [2:0] m, input logic [2:0] s,
                           input logic w, input int dur, input int sens_from, input int ped_at,
                           input logic [2:0] nxm, input logic [2:0] nxs, input logic nxw,
                           input int nxdur);
    for (int k = 1; k <= dur; k++) begin
      logic sens;
      logic p;
      sens = (sens_from != 0) && (k >= sens_from);
      p = (k == ped_at);
      if (k < dur) tick_expect(sens, p, m, s, w, dur - k, nm);
      else tick_expect(sens, p, nxm, nxs, nxw, nxdur, {nm, "_exit"});
    end
  endtask

  task automatic do_reset(input string nm);
    step(1'b0, 1'b0, 1'b0, 1'b1, R, R, 1'b0, 1, nm);
  endtask

  initial begin
    @(negedge clk);
    // Reset held 3 cycles, then a non-tick cycle holds, then the first tick enters main green.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, R, R, 1'b0, 1, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, R, 1'b0, 1, "reset_hold");
    tick_expect(1'b0, 1'b0, G, R, 1'b0, 10, "reset_exit");

    // No demand: main green holds, timer saturates at 0.
    for (int k = 1; k <= 30; k++)
      tick_expect(1'b0, 1'b0, G, R, 1'b0, (k < 10) ? 10 - k : 0, "no_demand");

    // Side demand from tick 4 of main green: full side cycle.
    do_reset("reset2");
    tick_expect(1'b0, 1'b0, G, R, 1'b0, 10, "enter_mg");
    run_phase("main_g", G, R, 1'b0, 10, 4, 0, Y, R, 1'b0, 3);
    run_phase("main_y", Y, R, 1'b0, 3, 1, 0, R, R, 1'b0, 1);
    run_phase("all_red1", R, R, 1'b0, 1, 1, 0, R, G, 1'b0, 6);
    run_phase("side_g", R, G, 1'b0, 6, 1, 0, R, Y, 1'b0, 3);
    run_phase("side_y", R, Y, 1'b0, 3, 1, 0, R, R, 1'b0, 1);
    run_phase("all_red2", R, R, 1'b0, 1, 1, 0, G, R, 1'b0, 10);

`ifdef TL_PED_CROSSING_EN
    // One-cycle pedestrian request at tick 2, no side demand: walk phase.
    do_reset("reset_ped");
    tick_expect(1'b0, 1'b0, G, R, 1'b0, 10, "ped_enter_mg");
    run_phase("ped_main_g", G, R, 1'b0, 10, 0, 2, Y, R, 1'b0, 3);
    run_phase("ped_main_y", Y, R, 1'b0, 3, 0, 0, R, R, 1'b0, 1);
    run_phase("ped_all_red1", R, R, 1'b0, 1, 0, 0, R, R, 1'b1, 5);
    run_phase("ped_walk", R, R, 1'b1, 5, 0, 0, R, R, 1'b0, 1);
    run_phase("ped_all_red2", R, R, 1'b0, 1, 0, 0, G, R, 1'b0, 10);
`else
    // Pedestrian logic absent: held request changes nothing.
    do_reset("reset_noped");
    tick_expect(1'b0, 1'b1, G, R, 1'b0, 10, "noped_enter_mg");
    for (int k = 1; k <= 40; k++)
      tick_expect(1'b0, 1'b1, G, R, 1'b0, (k < 10) ? 10 - k : 0, "noped_hold");
`endif

    // Reset coincident with a tick mid side green aborts at once; pending request is lost.
    do_reset("reset_mid");
    tick_expect(1'b1, 1'b0, G, R, 1'b0, 10, "mid_enter_mg");
    run_phase("mid_main_g", G, R, 1'b0, 10, 1, 0, Y, R, 1'b0, 3);
    run_phase("mid_main_y", Y, R, 1'b0, 3, 1, 0, R, R, 1'b0, 1);
    run_phase("mid_all_red1", R, R, 1'b0, 1, 1, 0, R, G, 1'b0, 6);
    tick_expect(1'b1, 1'b0, R, G, 1'b0, 5, "mid_side_g");
    tick_expect(1'b1, 1'b1, R, G, 1'b0, 4, "mid_side_g_ped");
    step(1'b1, 1'b1, 1'b1, 1'b1, R, R, 1'b0, 1, "mid_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, R, R, 1'b0, 1, "mid_reset_hold");
    tick_expect(1'b0, 1'b0, G, R, 1'b0, 10, "post_reset_mg");
    for (int k = 1; k <= 12; k++)
      tick_expect(1'b0, 1'b0, G, R, 1'b0, (k < 10) ? 10 - k : 0, "post_reset_hold");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
